// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Loads a program from a valid/ready word stream into an on-chip instruction
// memory. When the word flagged ld_last arrives, the block arms for one cycle
// and then raises start so the core can run. The core fetches through a
// one-cycle registered read port. halt returns the block to IDLE from any
// state.
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   rst         asynchronous, active-high reset
//   ld_valid    load-stream word valid
//   ld_data     load-stream instruction word
//   ld_last     final word of the program (qualified by ld_valid)
//   ld_ready    loader accepts a word this cycle (IDLE or LOAD)
//   halt        abort the load or run and return to IDLE
//   start       run enable to the core datapath (high only in RUN)
//   imem_en     fetch read enable
//   imem_addr   fetch word address
//   imem_data   fetched instruction, registered; 0 for unloaded words
//   load_count  number of words stored, saturating at DEPTH
//   load_err    sticky overflow flag (more words offered than DEPTH)
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int INST_ADDR_WIDTH = 8,
    parameter int INST_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    input  logic [INST_DATA_WIDTH-1:0] ld_data,
    input  logic                       ld_last,
    output logic                       ld_ready,
    input  logic                       halt,
    output logic                       start,
    input  logic                       imem_en,
    input  logic [INST_ADDR_WIDTH-1:0] imem_addr,
    output logic [INST_DATA_WIDTH-1:0] imem_data,
    output logic [INST_ADDR_WIDTH:0]   load_count,
    output logic                       load_err
);

    localparam int DEPTH = 2 ** INST_ADDR_WIDTH;
    // DEPTH expressed at the width of the counter (a single 1 in the MSB).
    localparam logic [INST_ADDR_WIDTH:0] DEPTH_W = {1'b1, {INST_ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ARM  = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t                       state_reg;
    logic                         ld_ready_reg;
    logic                         start_reg;
    logic [INST_ADDR_WIDTH:0]     count_reg;
    logic                         err_reg;
    logic [INST_DATA_WIDTH-1:0]   rdata_reg;

    // Instruction memory: plain array, no reset, so it maps onto block RAM.
    logic [INST_DATA_WIDTH-1:0]   mem [DEPTH];

    logic                         handshake;
    logic                         room;
    logic                         wr_en;
    logic [INST_ADDR_WIDTH-1:0]   wr_addr;
    logic                         fetch_hit;

    assign handshake = ld_valid && ld_ready_reg;
    assign room      = (count_reg < DEPTH_W);

    // A word is stored only on an accepted handshake that halt does not
    // cancel: always in IDLE (word 0), and in LOAD while space remains.
    // rst also gates the write so nothing lands in memory while it is held.
    assign wr_en   = handshake && !halt && !rst &&
                     ((state_reg == IDLE) || ((state_reg == LOAD) && room));
    assign wr_addr = (state_reg == IDLE) ? '0 : count_reg[INST_ADDR_WIDTH-1:0];

    // Only words inside the loaded program are visible, and only while running.
    assign fetch_hit = (state_reg == RUN) && ({1'b0, imem_addr} < count_reg);

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ld_ready_reg <= 1'b1;
            start_reg    <= 1'b0;
            count_reg    <= '0;
            err_reg      <= 1'b0;
        end else if (halt) begin
            // halt wins over everything, including a same-cycle handshake.
            state_reg    <= IDLE;
            ld_ready_reg <= 1'b1;
            start_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (handshake) begin
                        count_reg <= {{INST_ADDR_WIDTH{1'b0}}, 1'b1};
                        err_reg   <= 1'b0;
                        if (ld_last) begin
                            state_reg    <= ARM;
                            ld_ready_reg <= 1'b0;
                        end else begin
                            state_reg <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        // Once full, further words are dropped and flagged;
                        // the counter saturates instead of wrapping.
                        if (room) begin
                            count_reg <= count_reg + 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                        if (ld_last) begin
                            state_reg    <= ARM;
                            ld_ready_reg <= 1'b0;
                        end
                    end
                end
                ARM: begin
                    state_reg <= RUN;
                    start_reg <= 1'b1;
                end
                RUN: begin
                    state_reg <= RUN;
                end
                default: begin
                    state_reg    <= IDLE;
                    ld_ready_reg <= 1'b1;
                    start_reg    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= ld_data;
        end
    end

    // ------------------------------------------------------------------
    // Registered fetch port; holds its value while imem_en is low
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (imem_en) begin
            rdata_reg <= fetch_hit ? mem[imem_addr] : '0;
        end
    end

    assign ld_ready   = ld_ready_reg;
    assign start      = start_reg;
    assign load_count = count_reg;
    assign load_err   = err_reg;
    assign imem_data  = rdata_reg;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter INST_ADDR_WIDTH, default 8: instruction word-address width; DEPTH = 2**INST_ADDR_WIDTH words.
REQ-002 Parameter INST_DATA_WIDTH, default 32: instruction word width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ld_valid  in  1  load-stream word valid.
REQ-006 ld_data  in  INST_DATA_WIDTH  load-stream instruction word.
REQ-007 ld_last  in  1  marks the final word of the program; qualified by ld_valid.
REQ-008 ld_ready  out  1  loader can accept a word this cycle.
REQ-009 halt  in  1  abort load or run; return to IDLE.
REQ-010 start  out  1  run enable to the core datapath.
REQ-011 imem_en  in  1  fetch read enable from the core.
REQ-012 imem_addr  in  INST_ADDR_WIDTH  fetch word address.
REQ-013 imem_data  out  INST_DATA_WIDTH  fetched instruction, registered.
REQ-014 load_count  out  INST_ADDR_WIDTH+1  number of words stored, saturating at DEPTH.
REQ-015 load_err  out  1  sticky overflow flag.

Function
REQ-016 The block SHALL be a 4-state FSM: IDLE, LOAD, ARM, RUN.
REQ-017 A load handshake SHALL occur on a posedge where ld_valid and ld_ready are both 1.
REQ-018 ld_ready SHALL be 1 in IDLE and LOAD, and 0 in ARM and RUN.
REQ-019 In IDLE, a handshake SHALL write ld_data to word 0, set load_count=1, clear load_err, and move to LOAD, or to ARM if ld_last=1.
REQ-020 In LOAD with load_count<DEPTH, a handshake SHALL write ld_data to word load_count and increment load_count.
REQ-021 In LOAD with load_count==DEPTH, a handshake SHALL discard the word, set load_err=1, and hold load_count at DEPTH.
REQ-022 In LOAD, a handshake with ld_last=1 SHALL move to ARM after the write or discard.
REQ-023 ARM SHALL last exactly one cycle, then move to RUN.
REQ-024 start SHALL be 1 only in RUN, so it rises one cycle after the last-word handshake edge.
REQ-025 halt=1 at a posedge SHALL force IDLE from any state; a handshake in that same cycle SHALL be ignored (no write, no count change). halt SHALL take priority over all other events.
REQ-026 load_count and load_err SHALL hold their values in IDLE until the next IDLE handshake.
REQ-027 Fetch SHALL have one-cycle latency: if imem_en=1 at edge N, imem_data after edge N equals mem[imem_addr] sampled at edge N.
REQ-028 If imem_en=0, imem_data SHALL hold its previous value.
REQ-029 A fetch with imem_addr>=load_count, or with state not RUN, SHALL return 0 (NOP).
REQ-030 Memory contents SHALL NOT be reset and SHALL NOT be written in ARM or RUN.
REQ-031 load_count arithmetic SHALL use INST_ADDR_WIDTH+1 bits with no wrap; the write address is load_count[INST_ADDR_WIDTH-1:0].

Reset
REQ-032 While rst=1, the block SHALL force: state IDLE, start=0, imem_data=0, load_count=0, load_err=0. ld_ready SHALL be 1 (IDLE).
REQ-033 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation immediately, without waiting for a clock edge.
REQ-034 After reset, no memory write SHALL occur until a new IDLE handshake.

Verification
REQ-035 Load 3 words {0x11,0x22,0x33} with ld_last on the third -> load_count=3, ARM for 1 cycle, then start=1; fetches of addr 0,1,2 return 0x11,0x22,0x33 one cycle later; addr 3 returns 0.
REQ-036 Single word 0xABCD with ld_valid=ld_last=1 in IDLE -> load_count=1, start=1 two edges later, fetch addr 0 = 0xABCD.
REQ-037 INST_ADDR_WIDTH=2: stream 6 words with ld_last on the 6th -> load_count=4, load_err=1, words 4-5 absent, start=1.
REQ-038 Fetch in RUN, then imem_en=0 for 3 cycles -> imem_data holds its value. Fetch during LOAD -> 0.
REQ-039 halt=1 together with a handshake in LOAD at count=2 -> IDLE, count stays 2, start=0. A new load then restarts at word 0 and clears load_err.
REQ-040 rst pulsed between edges in RUN -> start=0, imem_data=0, load_count=0 immediately. A subsequent 2-word load runs normally.
